uart_tx_fifo: RTL and testbench

- Byte buffer between the LPC target's transmit-holding-register write strobe and the uart_tx serializer.
- Absorbs back-to-back host writes while the serializer is shifting a frame.
- Issues one byte at a time to uart_tx using its valid-pulse/busy handshake.
- Reports full/empty/count back to the LPC block for its line-status register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the LPC-side UART transmit path.
// Holds the issue FSM state encoding, default FIFO depth and the byte type.
package uart_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GUARD
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the LPC THR write strobe and the uart_tx serializer.
// Optional sticky overrun flag is enabled by defining UART_TX_FIFO_OVERRUN_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                LPC_CLK,
  input  logic                LPC_RST,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_busy
`ifdef UART_TX_FIFO_OVERRUN_EN
  ,
  output logic                overrun,
  input  logic                overrun_clr
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  byte_t                 mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  push;
  logic                  pop;
  state_t                state;
  state_t                state_next;

  // The extra pointer MSB distinguishes a full FIFO from an empty one.
  assign wr_addr = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_addr = rd_ptr[DEPTH_LOG2-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_addr == rd_addr) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign count   = wr_ptr - rd_ptr;
  assign push    = in_valid && !full;
  assign pop     = (state == IDLE) && !empty && !out_busy;

  always_ff @(posedge LPC_CLK) begin
    if (push) begin
      mem[wr_addr] <= in_data;
    end
  end

  always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
    if (!LPC_RST) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // out_data is only reloaded on a pop so it stays stable through the frame.
  always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
    if (!LPC_RST) begin
      rd_ptr   <= '0;
      out_data <= 8'h00;
    end else if (pop) begin
      rd_ptr   <= rd_ptr + PTR_ONE;
      out_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
    if (!LPC_RST) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= (state == ISSUE);
    end
  end

  // GUARD holds off the next pop until uart_tx has had a cycle to raise busy.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = ISSUE;
      ISSUE:   state_next = GUARD;
      GUARD:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_TX_FIFO_OVERRUN_EN
  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
    if (!LPC_RST) begin
      overrun <= 1'b0;
    end else if (in_valid && full) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple uart_tx busy model.
// Define UART_TX_FIFO_OVERRUN_EN to also exercise the overrun flag.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic       LPC_CLK;
  logic       LPC_RST;
  logic [7:0] in_data;
  logic       in_valid;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_busy;
`ifdef UART_TX_FIFO_OVERRUN_EN
  logic       overrun;
  logic       overrun_clr;
`endif

  logic  force_busy;
  logic  ser_busy;
  int    frame_len;
  int    passed;
  int    total;
  int    cyc;
  int    issue_count;
  int    last_issue;
  int    prev_issue;
  byte_t sb_q[$];

  assign out_busy = force_busy | ser_busy;

  uart_tx_fifo dut (
    .LPC_CLK   (LPC_CLK),
    .LPC_RST   (LPC_RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_busy  (out_busy)
`ifdef UART_TX_FIFO_OVERRUN_EN
    ,
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`endif
  );

  initial begin
    LPC_CLK = 1'b0;
    forever #5 LPC_CLK = ~LPC_CLK;
  end

  always @(posedge LPC_CLK) cyc <= cyc + 1;

  // uart_tx model: busy rises the cycle after out_valid and lasts frame_len cycles.
  initial begin
    ser_busy = 1'b0;
    forever begin
      @(posedge LPC_CLK);
      if (out_valid) begin
        #1 ser_busy = 1'b1;
        repeat (frame_len) @(posedge LPC_CLK);
        #1 ser_busy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every issue pulse must match the oldest accepted byte.
  always @(negedge LPC_CLK) begin
    byte_t exp_b;
    if (LPC_RST === 1'b1 && out_valid === 1'b1) begin
      prev_issue  = last_issue;
      last_issue  = cyc;
      issue_count = issue_count + 1;
      if (sb_q.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected_issue: got %0h expected none", out_data);
      end else begin
        exp_b = sb_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(exp_b));
      end
      checkOutput("busy_low_at_issue", 32'(out_busy), 32'd0);
    end
  end

  // Caller must be at a negedge; consecutive calls give back-to-back pushes.
  task automatic applyStimulus(input byte_t d, input bit accept);
    in_data  = d;
    in_valid = 1'b1;
    if (accept) sb_q.push_back(d);
    @(negedge LPC_CLK);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while (!(empty && sb_q.size() == 0 && !out_busy && !out_valid) && n < max_cycles) begin
      @(negedge LPC_CLK);
      n++;
    end
    if (n >= max_cycles) begin
      total++;
      $display("[TB] FAIL drain_timeout: got %0d cycles expected < %0d", n, max_cycles);
    end
    repeat (4) @(negedge LPC_CLK);
  endtask

  initial begin
    int n;
    int start_issues;
    int idx;
    int bursts [6];
    passed = 0; total = 0; cyc = 0;
    issue_count = 0; last_issue = 0; prev_issue = 0;
    frame_len = 2; force_busy = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
`ifdef UART_TX_FIFO_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    bursts = '{7, 7, 7, 7, 7, 5};

    // Power-on reset
    LPC_RST = 1'b1;
    #2 LPC_RST = 1'b0;
    repeat (2) @(negedge LPC_CLK);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
`ifdef UART_TX_FIFO_OVERRUN_EN
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
`endif
    LPC_RST = 1'b1;
    repeat (2) @(negedge LPC_CLK);

    // Single byte: push at edge N, pop at N+1, out_valid after N+2
    applyStimulus(8'hA5, 1'b1);
    checkOutput("single_count1", 32'(count), 32'd1);
    @(negedge LPC_CLK);
    checkOutput("single_count0", 32'(count), 32'd0);
    checkOutput("single_no_valid_yet", 32'(out_valid), 32'd0);
    @(negedge LPC_CLK);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_data", 32'(out_data), 32'hA5);
    @(negedge LPC_CLK);
    checkOutput("single_valid_pulse", 32'(out_valid), 32'd0);
    waitDrain(200);

    // Fill and overflow with the serializer held busy
    force_busy = 1'b1;
    @(negedge LPC_CLK);
    for (int i = 0; i < 17; i++) applyStimulus(byte_t'(i), i < 16);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_count", 32'(count), 32'd16);
    checkOutput("fill_not_empty", 32'(empty), 32'd0);
`ifdef UART_TX_FIFO_OVERRUN_EN
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge LPC_CLK);
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);
    overrun_clr = 1'b1;
    applyStimulus(8'hEE, 1'b0);
    overrun_clr = 1'b0;
    checkOutput("overrun_set_wins", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge LPC_CLK);
    overrun_clr = 1'b0;
`endif
    checkOutput("drop_count", 32'(count), 32'd16);
    force_busy = 1'b0;
    waitDrain(500);
    checkOutput("fill_drained", 32'(sb_q.size()), 32'd0);

    // Busy stall: issue spacing is frame_len + 3 cycles
    frame_len = 100;
    start_issues = issue_count;
    applyStimulus(8'h31, 1'b1);
    applyStimulus(8'h32, 1'b1);
    n = 0;
    while (issue_count < start_issues + 2 && n < 500) begin
      @(negedge LPC_CLK);
      n++;
    end
    if (n >= 500) begin
      total++;
      $display("[TB] FAIL stall_timeout: got %0d issues expected %0d", issue_count - start_issues, 2);
    end
    checkOutput("stall_spacing", 32'(last_issue - prev_issue), 32'd103);
    waitDrain(500);
    frame_len = 2;

    // Simultaneous push and pop at count 5
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(byte_t'(8'h51 + i), 1'b1);
    checkOutput("simul_count_before", 32'(count), 32'd5);
    force_busy = 1'b0;
    applyStimulus(8'h56, 1'b1);
    checkOutput("simul_count_after", 32'(count), 32'd5);
    waitDrain(500);

    // Wrap: 40 bytes in bursts across the pointer rollover
    frame_len = 1;
    idx = 0;
    foreach (bursts[b]) begin
      for (int k = 0; k < bursts[b]; k++) begin
        applyStimulus(byte_t'(8'h80 + idx), 1'b1);
        idx++;
      end
      checkOutput("wrap_not_full", 32'(full), 32'd0);
      waitDrain(300);
      checkOutput("wrap_empty", 32'(empty), 32'd1);
      checkOutput("wrap_count", 32'(count), 32'd0);
    end
    frame_len = 2;

    // Reset mid-stream while an issue pulse is high
    force_busy = 1'b1;
    applyStimulus(8'hC1, 1'b1);
    applyStimulus(8'hC2, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    force_busy = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(negedge LPC_CLK);
      n++;
    end
    checkOutput("midrst_valid_seen", 32'(out_valid), 32'd1);
    #1 LPC_RST = 1'b0;
    #1;
    checkOutput("midrst_empty", 32'(empty), 32'd1);
    checkOutput("midrst_full", 32'(full), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'h00);
    sb_q.delete();
    repeat (3) @(negedge LPC_CLK);
    LPC_RST = 1'b1;
    repeat (3) @(negedge LPC_CLK);
    checkOutput("post_rst_empty", 32'(empty), 32'd1);
    checkOutput("post_rst_no_issue", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
